// File: rtl/uart_tx_engine.sv
// UART transmit back-end: rising-edge-triggered byte FIFO feeding a baud-timed 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_engine #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 115_200,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_start,
  input  logic                          clr_overflow,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned AW           = $clog2(FIFO_DEPTH);
  localparam int unsigned LW           = AW + 1;
  localparam int unsigned CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            line_q, line_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            start_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            push_c, pop_c, accept_c, bit_end_c, fifo_empty_c;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  // Next-state: frame sequencing, FIFO bookkeeping and the registered line value.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    ovf_d        = ovf_q;
    line_d       = 1'b1;
    done_d       = 1'b0;
    pop_c        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    fifo_empty_c = (level_q == LW'(0));
    bit_end_c    = (cnt_q == CW'(CLKS_PER_BIT - 1));
    push_c       = tx_start & ~start_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = CW'(0);
        if (!fifo_empty_c) begin
          pop_c   = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          cnt_d   = CW'(0);
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          cnt_d = CW'(0);
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_c) begin
          state_d = S_STOP;
          cnt_d   = CW'(0);
        end
      end
`endif
      S_STOP: begin
        if (bit_end_c) begin
          cnt_d = CW'(0);
          if (!fifo_empty_c) begin
            pop_c   = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop_c) begin
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
`ifdef UART_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end

    // A full FIFO still accepts a push when the same edge frees a slot.
    accept_c = push_c && ((level_q != LW'(FIFO_DEPTH)) || pop_c);
    if (accept_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (accept_c && !pop_c)      level_d = level_q + LW'(1);
    else if (!accept_c && pop_c) level_d = level_q - LW'(1);

    if (push_c && !accept_c) ovf_d = 1'b1;
    else if (clr_overflow)   ovf_d = 1'b0;

    case (state_d)
      S_START:    line_d = 1'b0;
      S_DATA:     line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY:   line_d = parity_d;
`endif
      default:    line_d = 1'b1;
    endcase
    done_d = (state_d == S_STOP) && (cnt_d == CW'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q  <= S_IDLE;
      cnt_q    <= CW'(0);
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      line_q   <= 1'b1;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      start_q  <= 1'b0;
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      level_q  <= LW'(0);
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      line_q   <= line_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      start_q  <= tx_start;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge ACLK) begin
    if (accept_c) mem_q[wr_ptr_q] <= tx_data;
  end

  assign uart_tx    = line_q;
  assign tx_done    = done_q;
  assign overflow   = ovf_q;
  assign fifo_level = level_q;
  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign tx_busy    = (state_q != S_IDLE) || (level_q != LW'(0));

endmodule
